// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the front-end hazard/stall control slice.
package hazard_stall_unit_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_e;

    // Control vector order: {PC_Write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble}
    localparam logic [3:0]  CTRL_NOP     = 4'b0000;
    localparam int          REG_W_DEF    = 5;
    localparam logic [31:0] PC_RESET_VEC = 32'h0040_0000;

endpackage

// File: rtl/hazard_stall_unit_md_counter.sv
// Load/decrement occupancy counter; done flags the last MD_BUSY cycle.
module md_occupancy_counter #(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);
    localparam int CW = $clog2(LATENCY + 1);

    logic [CW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = CW'(LATENCY - 1);
        else if (dec && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// PC/IF-ID/ID-EX stall and flush control with mult/div occupancy, fetch watchdog and stall statistics.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W      = REG_W_DEF,
    parameter int MD_LATENCY = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_RegisterRt,
    input  logic [REG_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_W-1:0] IF_ID_RegisterRt,
    input  logic             ID_MultDiv,
    input  logic             BranchTaken,
    input  logic             IMem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             MD_Busy,
    output logic             Fetch_Timeout,
    output logic [CNT_W-1:0] Stall_Count
);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_e           state_d, state_q;
    logic [3:0]       ctrl;
    logic             lu, md_load, md_dec, md_done;
    logic [WW-1:0]    wait_d, wait_q;
    logic             timeout_d, timeout_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign lu = ID_EX_MemRead && (ID_EX_RegisterRt != '0) &&
                ((ID_EX_RegisterRt == IF_ID_RegisterRs) || (ID_EX_RegisterRt == IF_ID_RegisterRt));

    // A branch seen while MD_BUSY is illegal and simply falls through to the MD hold.
    always_comb begin
        ctrl = CTRL_NOP;
        if (reset)
            ctrl = CTRL_NOP;
        else if (state_q == ST_RUN && BranchTaken)
            ctrl = 4'b0011;
        else if (state_q == ST_MD_BUSY)
            ctrl = 4'b1101;
        else if (lu)
            ctrl = 4'b1101;
        else if (!IMem_Ready)
            ctrl = 4'b1010;
    end

    assign {PC_Write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble} = ctrl;

    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        md_dec  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ID_MultDiv && !lu && !BranchTaken) begin
                    state_d = ST_MD_BUSY;
                    md_load = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                md_dec = 1'b1;
                if (md_done) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    md_occupancy_counter #(.LATENCY(MD_LATENCY)) u_md_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .dec   (md_dec),
        .done  (md_done)
    );

    always_comb begin
        if (IMem_Ready)
            wait_d = '0;
        else if (wait_q == WW'(TIMEOUT))
            wait_d = wait_q;
        else
            wait_d = wait_q + 1'b1;
        timeout_d = timeout_q || (wait_d == WW'(TIMEOUT));
        cnt_d     = (PC_Write && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign MD_Busy       = (state_q == ST_MD_BUSY);
    assign Fetch_Timeout = timeout_q;
    assign Stall_Count   = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mr = 1'b0, md = 1'b0, br = 1'b0, rdy = 1'b1;
    logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;

    logic        pcw, hold, flush, bub, mdb, to;
    logic [15:0] cnt;
    logic        pcw4, hold4, flush4, bub4, mdb4, to4;
    logic [3:0]  cnt4;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [3:0] ctl;
        logic       chk_st;
        logic       md;
        logic       to;
        logic       chk_cnt;
        logic [15:0] cnt;
        logic [3:0] cnt4;
    } exp_t;

    exp_t  eq[$];
    string nq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_stall_unit dut (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(mr), .ID_EX_RegisterRt(ex_rt),
        .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt),
        .ID_MultDiv(md), .BranchTaken(br), .IMem_Ready(rdy),
        .PC_Write(pcw), .IF_ID_Hold(hold), .IF_ID_Flush(flush), .ID_EX_Bubble(bub),
        .MD_Busy(mdb), .Fetch_Timeout(to), .Stall_Count(cnt)
    );

    hazard_stall_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .ID_EX_MemRead(mr), .ID_EX_RegisterRt(ex_rt),
        .IF_ID_RegisterRs(id_rs), .IF_ID_RegisterRt(id_rt),
        .ID_MultDiv(md), .BranchTaken(br), .IMem_Ready(rdy),
        .PC_Write(pcw4), .IF_ID_Hold(hold4), .IF_ID_Flush(flush4), .ID_EX_Bubble(bub4),
        .MD_Busy(mdb4), .Fetch_Timeout(to4), .Stall_Count(cnt4)
    );

    task automatic drive(input logic r, input logic m, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic mdv, input logic b, input logic ry);
        @(posedge clk);
        #1;
        reset = r; mr = m; ex_rt = ert; id_rs = rs; id_rt = rt;
        md = mdv; br = b; rdy = ry;
    endtask

    task automatic idle(input logic r, input logic ry);
        drive(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ry);
    endtask

    // ctl = {PC_Write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble}; narrow build saturates at 15
    task automatic expect_c(input string n, input logic [3:0] ctl, input logic chk_st,
                            input logic m, input logic t, input logic chk_cnt, input int c);
        exp_t e;
        e.cyc = cyc; e.ctl = ctl; e.chk_st = chk_st; e.md = m; e.to = t;
        e.chk_cnt = chk_cnt; e.cnt = 16'(c);
        e.cnt4 = (c > 15) ? 4'd15 : 4'(c);
        eq.push_back(e);
        nq.push_back(n);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (!reset && br && mdb) begin
            errors++;
            $display("FAIL branch_in_md_busy cyc=%0d", cyc);
        end
        while (eq.size() > 0 && eq[0].cyc == cyc) begin
            e = eq.pop_front();
            n = nq.pop_front();
            checks++;
            if ({pcw, hold, flush, bub} !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b cyc=%0d", n, {pcw, hold, flush, bub}, e.ctl, cyc);
            end
            if (hold && flush) begin
                errors++;
                $display("FAIL %s hold_and_flush cyc=%0d", n, cyc);
            end
            if (e.chk_st) begin
                checks++;
                if ({mdb, to} !== {e.md, e.to}) begin
                    errors++;
                    $display("FAIL %s md_busy/timeout got=%b%b exp=%b%b", n, mdb, to, e.md, e.to);
                end
            end
            if (e.chk_cnt) begin
                checks++;
                if (cnt !== e.cnt || cnt4 !== e.cnt4) begin
                    errors++;
                    $display("FAIL %s stall_count got=%0d/%0d exp=%0d/%0d", n, cnt, cnt4, e.cnt, e.cnt4);
                end
            end
        end
    end

    initial begin
        idle(1'b1, 1'b1);                         expect_c("rst0",      4'b0000, 1, 0, 0, 1, 0);

        drive(0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1);   expect_c("lu_rs",     4'b1101, 1, 0, 0, 1, 0);
        idle(0, 1);                               expect_c("lu_rel",    4'b0000, 1, 0, 0, 1, 1);
        drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 1);   expect_c("lu_rt0",    4'b0000, 1, 0, 0, 1, 1);
        drive(0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 1);   expect_c("lu_rt",     4'b1101, 1, 0, 0, 1, 1);
        idle(0, 1);                               expect_c("lu_rt_rel", 4'b0000, 1, 0, 0, 1, 2);
        drive(0, 0, 5'd8, 5'd8, 5'd8, 0, 0, 1);   expect_c("no_memrd",  4'b0000, 1, 0, 0, 1, 2);
        idle(1, 1);                               expect_c("rst1",      4'b0000, 1, 0, 0, 1, 2);

        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1);   expect_c("md_issue",  4'b0000, 1, 0, 0, 1, 0);
        idle(0, 1);                               expect_c("md_b1",     4'b1101, 1, 1, 0, 1, 0);
        idle(0, 0);                               expect_c("md_b2_nrd", 4'b1101, 1, 1, 0, 1, 1);
        idle(0, 1);                               expect_c("md_b3",     4'b1101, 1, 1, 0, 1, 2);
        idle(0, 1);                               expect_c("md_done",   4'b0000, 1, 0, 0, 1, 3);

        drive(0, 1, 5'd8, 5'd8, 5'd0, 1, 0, 1);   expect_c("lumd_lu",   4'b1101, 1, 0, 0, 1, 3);
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1);   expect_c("lumd_iss",  4'b0000, 1, 0, 0, 1, 4);
        for (int i = 0; i < 3; i++) begin
            idle(0, 1);                           expect_c("lumd_busy", 4'b1101, 1, 1, 0, 1, 4 + i);
        end
        idle(0, 1);                               expect_c("lumd_done", 4'b0000, 1, 0, 0, 1, 7);

        drive(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0);   expect_c("br_prio",   4'b0011, 1, 0, 0, 1, 7);
        idle(0, 1);                               expect_c("br_after",  4'b0000, 1, 0, 0, 1, 7);

        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 1);   expect_c("rm_issue",  4'b0000, 1, 0, 0, 1, 7);
        idle(0, 1);                               expect_c("rm_b1",     4'b1101, 1, 1, 0, 1, 7);
        idle(1, 1);                               expect_c("rm_b2_rst", 4'b0000, 1, 1, 0, 1, 8);
        idle(0, 1);                               expect_c("rm_after",  4'b0000, 1, 0, 0, 1, 0);

        for (int i = 0; i < 63; i++) begin
            idle(0, 0);                           expect_c("wd_low63",  4'b1010, 1, 0, 0, 1, i);
        end
        idle(0, 1);                               expect_c("wd_63_ok",  4'b0000, 1, 0, 0, 1, 63);
        for (int i = 0; i < 64; i++) begin
            idle(0, 0);                           expect_c("wd_low64",  4'b1010, 1, 0, 0, 1, 63 + i);
        end
        idle(0, 1);                               expect_c("wd_tmo",    4'b0000, 1, 0, 1, 1, 127);
        idle(0, 1);                               expect_c("wd_sticky", 4'b0000, 1, 0, 1, 1, 127);
        idle(1, 1);                               expect_c("wd_rst",    4'b0000, 1, 0, 1, 1, 127);
        idle(0, 1);                               expect_c("wd_clear",  4'b0000, 1, 0, 0, 1, 0);

        for (int i = 0; i < 20 && eq.size() > 0; i++) @(posedge clk);
        #1;
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", eq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline front-end control block. Drives the PC_Write hold input of the PC register and the IF/ID and ID/EX pipeline-register controls.
- Sources of stall or flush: load-use hazards, multi-cycle mult/div occupancy, instruction-memory wait, and taken branches resolved in EX.
- Sits between the ID/EX decode fields and the PC register / IF/ID / ID/EX registers. Also keeps a fetch-timeout watchdog and a stall-cycle statistic counter.

Parameters:
- REG_W, 5, register-specifier width
- MD_LATENCY, 4, mult/div EX occupancy in cycles (>=2)
- TIMEOUT, 64, consecutive IMem_Ready=0 cycles that raise Fetch_Timeout
- CNT_W, 16, Stall_Count width

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRt  in  REG_W  load destination
- IF_ID_RegisterRs  in  REG_W  source rs of instruction in ID
- IF_ID_RegisterRt  in  REG_W  source rt of instruction in ID
- ID_MultDiv  in  1  instruction in ID is mult/div
- BranchTaken  in  1  branch or jump in EX redirects PC this cycle
- IMem_Ready  in  1  instruction memory returns valid data this cycle
- PC_Write  out  1  1 = PC holds, 0 = PC loads NewPC
- IF_ID_Hold  out  1  IF/ID keeps its contents
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Bubble  out  1  ID/EX loads a NOP (control zeroed)
- MD_Busy  out  1  mult/div occupying EX
- Fetch_Timeout  out  1  sticky watchdog flag
- Stall_Count  out  CNT_W  cycles with PC_Write=1, saturating

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: state RUN, MD counter 0, wait counter 0, Fetch_Timeout=0, Stall_Count=0.
- State register: RUN or MD_BUSY.
- Output timing: the control outputs (PC_Write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble) are combinational from state and inputs (same-cycle effect). While reset is high, force these outputs to 0.
- LU (load-use) = ID_EX_MemRead & (ID_EX_RegisterRt!=0) & (ID_EX_RegisterRt==IF_ID_RegisterRs | ID_EX_RegisterRt==IF_ID_RegisterRt).
- Output priority, highest first:
  1. BranchTaken=1 (RUN only): PC_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, IF_ID_Hold=0. Applies regardless of IMem_Ready.
  2. MD_BUSY: PC_Write=1, IF_ID_Hold=1, ID_EX_Bubble=1.
  3. LU in RUN: PC_Write=1, IF_ID_Hold=1, ID_EX_Bubble=1. Lasts exactly 1 cycle, because the load advances.
  4. IMem_Ready=0 in RUN with no hold: PC_Write=1, IF_ID_Flush=1.
  5. Otherwise all four outputs are 0.
- IF_ID_Hold and IF_ID_Flush are never both 1; hold wins.
- Mult/div sequencing:
  - RUN -> MD_BUSY when ID_MultDiv=1, LU=0, BranchTaken=0 and IMem_Ready is irrelevant. The mult/div issues in that cycle with no stall. Counter loads MD_LATENCY-1.
  - In MD_BUSY: decrement each cycle. At counter==1, go to RUN next cycle. This gives exactly MD_LATENCY-1 stall cycles.
  - MD_Busy = (state==MD_BUSY).
  - ID_MultDiv with LU=1: the LU stall occurs first, and the mult/div issues on the following cycle.
- BranchTaken in MD_BUSY is a protocol violation: ignore it, and the bench asserts it never happens.
- Watchdog:
  - Wait counter increments on IMem_Ready=0 and clears on IMem_Ready=1, saturating at TIMEOUT.
  - Fetch_Timeout sets when the counter reaches TIMEOUT and stays set until reset.
- Stall_Count increments on every cycle with PC_Write=1 and saturates at all-ones.
- reset asserted mid-MD_BUSY: next cycle is RUN, no stall.

Decomposition:
- Shared package: state encoding (RUN/MD_BUSY), NOP control constant, REG_W default, and PC reset vector 32'h0040_0000 for consistency with the PC register.
- One natural sub-module: md_occupancy_counter, a load/decrement/done counter used for the MD_BUSY timing.

Test Plan:
- lw $t0 in EX (MemRead=1, Rt=8), ID Rs=8 -> PC_Write=1, IF_ID_Hold=1, ID_EX_Bubble=1 for 1 cycle. Repeat with Rt=0 -> no stall.
- ID_MultDiv=1, MD_LATENCY=4 -> issue cycle unstalled, then PC_Write=1 and MD_Busy=1 for exactly 3 cycles, then RUN. Stall_Count=3.
- BranchTaken=1 together with LU=1 and IMem_Ready=0 -> PC_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, IF_ID_Hold=0.
- IMem_Ready=0 for 63 cycles -> Fetch_Timeout=0. Ready for 1 cycle, then 0 for 64 cycles -> Fetch_Timeout=1, remains 1 after ready returns, clears on reset.
- reset high during 2nd MD_BUSY cycle -> next cycle MD_Busy=0, outputs 0, Stall_Count=0.
- Force Stall_Count near all-ones (CNT_W=4 build), continuous stalls -> holds at 15, no wrap.
